// File: rtl/prediction_stat_tracker.sv
// Per-predictor accuracy tracker for the SP/LHP/GHP predictors: in-flight prediction FIFO,
// saturating stat counts and one-hot trend decodes scored on branch resolution.
module prediction_stat_tracker #(
   parameter int unsigned STAT_COUNTER_WIDTH = 5,
   parameter int unsigned MISS_PENALTY       = 2,
   parameter int unsigned QUEUE_DEPTH        = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          pred_valid,
   output logic                          pred_ready,
   input  logic                          SP_prediction,
   input  logic                          LHP_prediction,
   input  logic                          GHP_prediction,
   input  logic                          resolve_valid,
   input  logic                          resolve_taken,
   input  logic                          flush,
   output logic [STAT_COUNTER_WIDTH-1:0] SP_stat_count,
   output logic [STAT_COUNTER_WIDTH-1:0] LHP_stat_count,
   output logic [STAT_COUNTER_WIDTH-1:0] GHP_stat_count,
   output logic [3:0]                    SP_trend_decode,
   output logic [3:0]                    LHP_trend_decode,
   output logic [3:0]                    GHP_trend_decode,
   output logic                          underflow_err
);

   localparam int unsigned W    = STAT_COUNTER_WIDTH;
   localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [W-1:0] StatMax = '1;
   localparam logic [W:0]   Penalty = (W+1)'(MISS_PENALTY);

   // Entry layout: bit2 = SP, bit1 = LHP, bit0 = GHP; predictor index i maps to bit 2-i.
   logic [2:0]      fifo_mem [QUEUE_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] occ_q, occ_d;
   logic [W-1:0]    stat_q [3];
   logic [W-1:0]    stat_d [3];
   logic [2:0]      hist_q [3];
   logic [2:0]      hist_d [3];
   logic [3:0]      trend_q [3];
   logic [3:0]      trend_d [3];
   logic            underflow_q, underflow_d;

   logic            empty, full, push, pop;
   logic [2:0]      head, pred_bits;
   logic            correct [3];
   logic [W:0]      diff [3];
   logic [1:0]      ones [3];

   assign empty      = (occ_q == '0);
   assign full       = (occ_q == CntW'(QUEUE_DEPTH));
   assign pred_ready = !full;
   // Flush drops a same-cycle push; a pop on an empty FIFO is an underflow, not a bypass.
   assign push       = pred_valid && !full && !flush;
   assign pop        = resolve_valid && !empty;
   assign head       = fifo_mem[rd_ptr_q];
   assign pred_bits  = {SP_prediction, LHP_prediction, GHP_prediction};

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      occ_d       = occ_q;
      underflow_d = underflow_q | (resolve_valid & empty);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         occ_d = occ_q + CntW'(push) - CntW'(pop);
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         correct[i] = (head[2-i] == resolve_taken);
         diff[i]    = {1'b0, stat_q[i]} - Penalty;
         stat_d[i]  = stat_q[i];
         hist_d[i]  = hist_q[i];
         if (pop) begin
            hist_d[i] = {hist_q[i][1:0], correct[i]};
            if (correct[i]) begin
               if (stat_q[i] != StatMax) stat_d[i] = stat_q[i] + W'(1);
            end else begin
               // Borrow out of the W+1 bit difference means the count would go negative.
               stat_d[i] = diff[i][W] ? '0 : diff[i][W-1:0];
            end
         end
         ones[i]    = {1'b0, hist_d[i][0]} + {1'b0, hist_d[i][1]} + {1'b0, hist_d[i][2]};
         trend_d[i] = 4'b0001 << ones[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
         underflow_q <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            stat_q[i]  <= '0;
            hist_q[i]  <= 3'b000;
            trend_q[i] <= 4'b0001;
         end
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         occ_q       <= occ_d;
         underflow_q <= underflow_d;
         for (int i = 0; i < 3; i++) begin
            stat_q[i]  <= stat_d[i];
            hist_q[i]  <= hist_d[i];
            trend_q[i] <= trend_d[i];
         end
      end
   end

   // Storage needs no reset: occupancy gates every read.
   always_ff @(posedge clk) begin
      if (rst_n && push) fifo_mem[wr_ptr_q] <= pred_bits;
   end

   assign SP_stat_count    = stat_q[0];
   assign LHP_stat_count   = stat_q[1];
   assign GHP_stat_count   = stat_q[2];
   assign SP_trend_decode  = trend_q[0];
   assign LHP_trend_decode = trend_q[1];
   assign GHP_trend_decode = trend_q[2];
   assign underflow_err    = underflow_q;

endmodule

// File: tb/tb_prediction_stat_tracker.sv
// Directed, table-driven bench for prediction_stat_tracker with hand-computed expectations.
module tb_prediction_stat_tracker;

   localparam int W = 5;

   logic         clk = 1'b0;
   logic         rst_n, pred_valid, pred_ready;
   logic         sp, lhp, ghp;
   logic         resolve_valid, resolve_taken, flush;
   logic [W-1:0] sp_cnt, lhp_cnt, ghp_cnt;
   logic [3:0]   sp_tr, lhp_tr, ghp_tr;
   logic         underflow_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   prediction_stat_tracker #(
      .STAT_COUNTER_WIDTH(W),
      .MISS_PENALTY      (2),
      .QUEUE_DEPTH       (4)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .pred_valid      (pred_valid),
      .pred_ready      (pred_ready),
      .SP_prediction   (sp),
      .LHP_prediction  (lhp),
      .GHP_prediction  (ghp),
      .resolve_valid   (resolve_valid),
      .resolve_taken   (resolve_taken),
      .flush           (flush),
      .SP_stat_count   (sp_cnt),
      .LHP_stat_count  (lhp_cnt),
      .GHP_stat_count  (ghp_cnt),
      .SP_trend_decode (sp_tr),
      .LHP_trend_decode(lhp_tr),
      .GHP_trend_decode(ghp_tr),
      .underflow_err   (underflow_err)
   );

   typedef struct {
      logic       pv, p_sp, p_lhp, p_ghp, rv, tk, fl, rn;
      int         e_sp, e_lhp, e_ghp;
      logic [3:0] t_sp, t_lhp, t_ghp;
      logic       e_rdy, e_uf;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, sample 1 ns later, return to idle.
   task automatic apply(input logic pv, p_sp, p_lhp, p_ghp, rv, tk, fl, rn);
      pred_valid    = pv;
      sp            = p_sp;
      lhp           = p_lhp;
      ghp           = p_ghp;
      resolve_valid = rv;
      resolve_taken = tk;
      flush         = fl;
      rst_n         = rn;
      @(posedge clk);
      #1;
      pred_valid    = 1'b0;
      resolve_valid = 1'b0;
      flush         = 1'b0;
      rst_n         = 1'b1;
   endtask

   task automatic check_all(input string tag, input int e_sp, e_lhp, e_ghp,
                            input logic [3:0] t_sp, t_lhp, t_ghp, input logic e_rdy, e_uf);
      check({tag, " SP_stat"}, 32'(sp_cnt), 32'(e_sp));
      check({tag, " LHP_stat"}, 32'(lhp_cnt), 32'(e_lhp));
      check({tag, " GHP_stat"}, 32'(ghp_cnt), 32'(e_ghp));
      check({tag, " SP_trend"}, 32'(sp_tr), 32'(t_sp));
      check({tag, " LHP_trend"}, 32'(lhp_tr), 32'(t_lhp));
      check({tag, " GHP_trend"}, 32'(ghp_tr), 32'(t_ghp));
      check({tag, " pred_ready"}, 32'(pred_ready), 32'(e_rdy));
      check({tag, " underflow"}, 32'(underflow_err), 32'(e_uf));
   endtask

   task automatic do_reset();
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      apply(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      //          pv sp lh gh rv tk fl rn  eSP eLHP eGHP tSP     tLHP     tGHP     rdy uf
      vecs[0] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0001, 4'b0001, 4'b0001, 1, 0};
      vecs[1] = '{1, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 4'b0001, 4'b0001, 4'b0001, 1, 0};
      vecs[2] = '{0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 1, 4'b0010, 4'b0001, 4'b0010, 1, 0};
      vecs[3] = '{0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 1, 4'b0010, 4'b0001, 4'b0010, 1, 1};
      // Reset mid-stream with push and resolve: reset wins, sticky error clears.
      vecs[4] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 4'b0001, 4'b0001, 4'b0001, 1, 0};

      pred_valid = 0; sp = 0; lhp = 0; ghp = 0;
      resolve_valid = 0; resolve_taken = 0; flush = 0; rst_n = 0;
      do_reset();

      for (int i = 0; i < 5; i++) begin
         apply(vecs[i].pv, vecs[i].p_sp, vecs[i].p_lhp, vecs[i].p_ghp,
               vecs[i].rv, vecs[i].tk, vecs[i].fl, vecs[i].rn);
         check_all($sformatf("vec%0d", i), vecs[i].e_sp, vecs[i].e_lhp, vecs[i].e_ghp,
                   vecs[i].t_sp, vecs[i].t_lhp, vecs[i].t_ghp, vecs[i].e_rdy, vecs[i].e_uf);
      end

      // Saturation: SP/LHP always right, GHP always wrong.
      do_reset();
      for (int i = 0; i < 40; i++) begin
         apply(1, 1, 1, 0, 0, 0, 0, 1);
         apply(0, 0, 0, 0, 1, 1, 0, 1);
      end
      check_all("sat", 31, 31, 0, 4'b1000, 4'b1000, 4'b0001, 1, 0);
      apply(1, 0, 0, 1, 0, 0, 0, 1);
      apply(0, 0, 0, 0, 1, 1, 0, 1);
      check_all("sat_miss", 29, 29, 1, 4'b0100, 4'b0100, 4'b0010, 1, 0);

      // Floor: count 1 then a miss lands on 0.
      do_reset();
      apply(1, 1, 0, 0, 0, 0, 0, 1);
      apply(0, 0, 0, 0, 1, 1, 0, 1);
      check("floor_pre SP_stat", 32'(sp_cnt), 32'd1);
      apply(1, 0, 0, 0, 0, 0, 0, 1);
      apply(0, 0, 0, 0, 1, 1, 0, 1);
      check("floor SP_stat", 32'(sp_cnt), 32'd0);
      check("floor SP_trend", 32'(sp_tr), 32'(4'b0010));

      // Full FIFO: the 5th push is refused even with a concurrent pop.
      do_reset();
      for (int i = 0; i < 4; i++) apply(1, 1, 1, 1, 0, 0, 0, 1);
      check("full pred_ready", 32'(pred_ready), 32'd0);
      apply(1, 0, 0, 0, 1, 1, 0, 1);
      check("after_full pred_ready", 32'(pred_ready), 32'd1);
      check("after_full SP_stat", 32'(sp_cnt), 32'd1);
      for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 1, 1, 0, 1);
      check_all("drain", 4, 4, 4, 4'b1000, 4'b1000, 4'b1000, 1, 0);
      apply(0, 0, 0, 0, 1, 1, 0, 1);
      check_all("drain_uf", 4, 4, 4, 4'b1000, 4'b1000, 4'b1000, 1, 1);

      // Flush with resolve: only the head is scored, then the FIFO is empty.
      do_reset();
      apply(1, 1, 0, 0, 0, 0, 0, 1);
      apply(1, 0, 1, 0, 0, 0, 0, 1);
      apply(1, 0, 0, 1, 0, 0, 0, 1);
      apply(0, 0, 0, 0, 1, 1, 1, 1);
      check_all("flush", 1, 0, 0, 4'b0010, 4'b0001, 4'b0001, 1, 0);
      apply(0, 0, 0, 0, 1, 1, 0, 1);
      check_all("flush_uf", 1, 0, 0, 4'b0010, 4'b0001, 4'b0001, 1, 1);

      // Flush with push: the push is dropped.
      do_reset();
      apply(1, 1, 1, 1, 0, 0, 1, 1);
      apply(0, 0, 0, 0, 1, 1, 0, 1);
      check_all("flush_push", 0, 0, 0, 4'b0001, 4'b0001, 4'b0001, 1, 1);

      // Same-cycle push and resolve on an empty FIFO is an underflow.
      do_reset();
      apply(1, 1, 1, 1, 1, 1, 0, 1);
      check_all("bypass_uf", 0, 0, 0, 4'b0001, 4'b0001, 4'b0001, 1, 1);
      apply(0, 0, 0, 0, 1, 1, 0, 1);
      check("bypass_pop SP_stat", 32'(sp_cnt), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
